// File: rtl/sseg_scan_decoder.sv
// Seven-segment scan-bus decoder: qualifies each multiplexed digit for stability and decodes it back to hex.
// Optional macro SSEG_DP_EN adds the decimal-point input dp_n and per-digit output dp.
module sseg_scan_decoder #(
    parameter int NUM_DIG       = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg_n,
    input  logic [NUM_DIG-1:0]   an_n,
`ifdef SSEG_DP_EN
    input  logic                 dp_n,
    output logic [NUM_DIG-1:0]   dp,
`endif
    output logic [4*NUM_DIG-1:0] digits,
    output logic [NUM_DIG-1:0]   dig_valid,
    output logic                 upd,
    output logic [2:0]           upd_idx,
    output logic                 dig_err
);

    localparam logic [7:0] CNT_FULL = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t             state_reg;
    logic [7:0]         cnt_reg;
    logic [6:0]         s_seg_reg;
    logic [NUM_DIG-1:0] s_an_reg;
    logic [6:0]         ref_seg_reg;
    logic [2:0]         ref_idx_reg;
    logic [3:0]         nib_reg [NUM_DIG];
    logic [NUM_DIG-1:0] val_reg;
    logic               upd_reg;
    logic [2:0]         upd_idx_reg;
    logic               dig_err_reg;
`ifdef SSEG_DP_EN
    logic               s_dp_reg;
    logic               ref_dp_reg;
    logic [NUM_DIG-1:0] dp_reg;
`endif

    logic [3:0] zero_cnt;
    logic [2:0] slot_idx;
    logic       slot_legal;
    logic       sample_match;
    logic [4:0] glyph;

    // {legal, nibble}; anything outside the 16 hex glyphs reports legal=0
    function automatic logic [4:0] decode_glyph(input logic [6:0] p);
        case (p)
            7'h40: return 5'h10;  7'h79: return 5'h11;
            7'h24: return 5'h12;  7'h30: return 5'h13;
            7'h19: return 5'h14;  7'h12: return 5'h15;
            7'h02: return 5'h16;  7'h78: return 5'h17;
            7'h00: return 5'h18;  7'h18: return 5'h19;
            7'h08: return 5'h1A;  7'h03: return 5'h1B;
            7'h27: return 5'h1C;  7'h21: return 5'h1D;
            7'h04: return 5'h1E;  7'h0E: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    always_comb begin
        zero_cnt = '0;
        slot_idx = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (!s_an_reg[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                slot_idx = 3'(i);
            end
        end
    end

    assign slot_legal   = (zero_cnt == 4'd1);
    assign glyph        = decode_glyph(s_seg_reg);
`ifdef SSEG_DP_EN
    assign sample_match = slot_legal && (slot_idx == ref_idx_reg) &&
                          (s_seg_reg == ref_seg_reg) && (s_dp_reg == ref_dp_reg);
`else
    assign sample_match = slot_legal && (slot_idx == ref_idx_reg) &&
                          (s_seg_reg == ref_seg_reg);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            s_seg_reg   <= '1;
            s_an_reg    <= '1;
            ref_seg_reg <= '0;
            ref_idx_reg <= '0;
            nib_reg     <= '{default: '0};
            val_reg     <= '0;
            upd_reg     <= 1'b0;
            upd_idx_reg <= '0;
            dig_err_reg <= 1'b0;
`ifdef SSEG_DP_EN
            s_dp_reg    <= 1'b1;
            ref_dp_reg  <= 1'b1;
            dp_reg      <= '0;
`endif
        end else begin
            s_seg_reg   <= seg_n;
            s_an_reg    <= an_n;
`ifdef SSEG_DP_EN
            s_dp_reg    <= dp_n;
`endif
            upd_reg     <= 1'b0;
            dig_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (slot_legal) begin
                        state_reg   <= TRACK;
                        cnt_reg     <= 8'd1;
                        ref_seg_reg <= s_seg_reg;
                        ref_idx_reg <= slot_idx;
`ifdef SSEG_DP_EN
                        ref_dp_reg  <= s_dp_reg;
`endif
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                TRACK, LOCKED: begin
                    if (!slot_legal) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (!sample_match) begin
                        state_reg   <= TRACK;
                        cnt_reg     <= 8'd1;
                        ref_seg_reg <= s_seg_reg;
                        ref_idx_reg <= slot_idx;
`ifdef SSEG_DP_EN
                        ref_dp_reg  <= s_dp_reg;
`endif
                    end else if (state_reg == TRACK) begin
                        if (cnt_reg >= CNT_LAST) begin
                            // Run reached the stability threshold: commit once, then hold
                            state_reg   <= LOCKED;
                            cnt_reg     <= CNT_FULL;
                            upd_reg     <= 1'b1;
                            upd_idx_reg <= slot_idx;
                            dig_err_reg <= !glyph[4] && (s_seg_reg != 7'h7F);
                            for (int i = 0; i < NUM_DIG; i++) begin
                                if (3'(i) == slot_idx) begin
                                    val_reg[i] <= glyph[4];
                                    if (glyph[4]) begin
                                        nib_reg[i] <= glyph[3:0];
                                    end
`ifdef SSEG_DP_EN
                                    dp_reg[i] <= ~s_dp_reg;
`endif
                                end
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_pack
            assign digits[4*gi +: 4] = nib_reg[gi];
        end
    endgenerate

    assign dig_valid = val_reg;
    assign upd       = upd_reg;
    assign upd_idx   = upd_idx_reg;
    assign dig_err   = dig_err_reg;
`ifdef SSEG_DP_EN
    assign dp        = dp_reg;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: run-length reference model checked every cycle, plus directed literal checks.
module tb_sseg_scan_decoder;

    localparam int NUM_DIG = 4;
    localparam int STABLE  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [6:0]           seg_n = 7'h7F;
    logic [NUM_DIG-1:0]   an_n = '1;
    logic [4*NUM_DIG-1:0] digits;
    logic [NUM_DIG-1:0]   dig_valid;
    logic                 upd;
    logic [2:0]           upd_idx;
    logic                 dig_err;

    sseg_scan_decoder #(.NUM_DIG(NUM_DIG), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .digits(digits), .dig_valid(dig_valid), .upd(upd),
        .upd_idx(upd_idx), .dig_err(dig_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int obs_upd = 0;
    int obs_err = 0;
    bit cmp_en = 1'b0;

    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h04, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a digit commits when a run of identical legal registered samples hits STABLE length
    logic [6:0]           m_seg, prev_seg;
    logic [NUM_DIG-1:0]   m_an, prev_an;
    int                   run_len;
    logic [4*NUM_DIG-1:0] exp_digits;
    logic [NUM_DIG-1:0]   exp_valid;
    logic                 exp_upd, exp_err;
    logic [2:0]           exp_idx;

    always @(posedge clk) begin
        if (rst) begin
            m_seg = 7'h7F; m_an = '1; prev_seg = '1; prev_an = '1; run_len = 0;
            exp_digits = '0; exp_valid = '0; exp_upd = 0; exp_err = 0; exp_idx = 0;
        end else begin
            int  idx;
            int  nib;
            exp_upd = 0;
            exp_err = 0;
            if ($countones(~m_an) != 1) run_len = 0;
            else if (run_len > 0 && m_an == prev_an && m_seg == prev_seg) run_len++;
            else run_len = 1;
            prev_an = m_an;
            prev_seg = m_seg;
            if (run_len == STABLE) begin
                idx = 0;
                for (int i = 0; i < NUM_DIG; i++) if (!m_an[i]) idx = i;
                nib = -1;
                for (int g = 0; g < 16; g++) if (glyphs[g] == m_seg) nib = g;
                exp_upd = 1;
                exp_idx = 3'(idx);
                if (nib >= 0) begin
                    exp_digits[4*idx +: 4] = 4'(nib);
                    exp_valid[idx] = 1'b1;
                end else begin
                    exp_valid[idx] = 1'b0;
                    exp_err = (m_seg != 7'h7F);
                end
            end
            m_seg = seg_n;
            m_an = an_n;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("digits", 32'(digits), 32'(exp_digits));
            check("dig_valid", 32'(dig_valid), 32'(exp_valid));
            check("upd", 32'(upd), 32'(exp_upd));
            check("dig_err", 32'(dig_err), 32'(exp_err));
            if (exp_upd) check("upd_idx", 32'(upd_idx), 32'(exp_idx));
            if (upd) begin
                obs_upd++;
                $display("commit idx=%0d digits=%h valid=%b err=%b", upd_idx, digits, dig_valid, dig_err);
            end
            if (dig_err) obs_err++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    logic [8:0] upd_hist;
    int r, hold;

    initial begin
        tick(3);
        cmp_en = 1'b1;
        rst = 1'b0;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_valid", 32'(dig_valid), 32'h0);
        check("reset_upd_idx", 32'(upd_idx), 32'h0);

        // Idle bus
        obs_upd = 0;
        tick(50);
        check("idle_upd_count", 32'(obs_upd), 32'd0);
        check("idle_digits", 32'(digits), 32'h0);

        // Single digit held: commit visible only after edge STABLE+1
        an_n = 4'b1110; seg_n = 7'h30;
        upd_hist = '0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            upd_hist[k] = upd;
        end
        check("latency_upd_hist", 32'(upd_hist), 32'h020);
        check("latency_digits", 32'(digits), 32'h0003);
        check("latency_valid", 32'(dig_valid), 32'h1);

        // Two scan rounds over four digits
        obs_upd = 0;
        for (int round = 0; round < 2; round++) begin
            an_n = 4'b1110; seg_n = 7'h12; tick(6);
            an_n = 4'b1101; seg_n = 7'h40; tick(6);
            an_n = 4'b1011; seg_n = 7'h0E; tick(6);
            an_n = 4'b0111; seg_n = 7'h79; tick(6);
        end
        an_n = 4'b1111; tick(3);
        check("scan_upd_count", 32'(obs_upd), 32'd8);
        check("scan_digits", 32'(digits), 32'h1F05);
        check("scan_valid", 32'(dig_valid), 32'hF);

        // Short slot does not commit, following slot does
        obs_upd = 0;
        an_n = 4'b1101; seg_n = 7'h24; tick(3);
        an_n = 4'b1110; tick(8);
        an_n = 4'b1111; tick(2);
        check("short_upd_count", 32'(obs_upd), 32'd1);
        check("short_digits", 32'(digits), 32'h1F02);

        // Blank then illegal pattern on digit 2
        obs_upd = 0; obs_err = 0;
        an_n = 4'b1011; seg_n = 7'h7F; tick(8);
        seg_n = 7'h55; tick(8);
        an_n = 4'b1111; tick(2);
        check("blank_illegal_upd_count", 32'(obs_upd), 32'd2);
        check("blank_illegal_err_count", 32'(obs_err), 32'd1);
        check("blank_illegal_digits", 32'(digits), 32'h1F02);
        check("blank_illegal_valid", 32'(dig_valid), 32'hB);

        // Two anodes low is never a valid slot
        obs_upd = 0;
        an_n = 4'b1100; seg_n = 7'h79; tick(10);
        check("two_low_upd_count", 32'(obs_upd), 32'd0);

        // Reset in the middle of tracking discards the pending commit
        obs_upd = 0;
        an_n = 4'b1110; seg_n = 7'h19; tick(3);
        rst = 1'b1; an_n = 4'b1111; tick(2);
        rst = 1'b0; tick(4);
        check("rst_track_upd_count", 32'(obs_upd), 32'd0);
        check("rst_track_digits", 32'(digits), 32'h0);
        check("rst_track_valid", 32'(dig_valid), 32'h0);
        check("rst_track_upd_idx", 32'(upd_idx), 32'h0);
        check("rst_track_err", 32'(dig_err), 32'h0);

        // Randomized scan traffic
        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 9);
            an_n = ~(4'b0001 << $urandom_range(0, 3));
            seg_n = glyphs[$urandom_range(0, 15)];
            if (r == 6) seg_n = 7'h7F;
            else if (r == 7) seg_n = 7'($urandom);
            else if (r == 8) an_n = 4'($urandom);
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1; tick(1); rst = 1'b0;
            end
            tick(hold);
        end
        an_n = 4'b1111; tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
Receive-side counterpart of the hex-to-seven-segment encoder. Monitors a time-multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode selects), qualifies each digit pattern for stability, and decodes it back to a 4-bit hex value per digit. Used as a loopback checker and capture front end for display drivers.

Parameters:
NUM_DIG, 4, number of multiplexed digits (anode lines), range 1..8
STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed, minimum 2, maximum 255

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
seg_n  input  7  segment lines, active low; bit0=a … bit6=g
an_n  input  NUM_DIG  digit selects, active low; exactly one low = valid scan slot
digits  output  4*NUM_DIG  decoded nibbles; digit i at [4i+3:4i]
dig_valid  output  NUM_DIG  bit i = digit i holds a committed legal hex glyph
upd  output  1  one-cycle pulse on each commit
upd_idx  output  3  index of the digit committed with upd
dig_err  output  1  one-cycle pulse, coincident with upd, when the committed pattern is illegal

Behaviour:
- Reset (rst=1 at an edge): digits=0, dig_valid=0, upd=0, upd_idx=0, dig_err=0, counter=0, FSM=IDLE, input sample registers=all ones.
- Input stage: seg_n and an_n are registered every cycle (s_seg, s_an). All decisions use registered samples only.
- Slot check: s_an is legal when exactly one bit is 0. Index = position of that bit.
- FSM states: IDLE, TRACK, LOCKED.
  - IDLE: s_an illegal -> stay, counter=0. Legal -> TRACK, counter=1, latch (idx, s_seg) as reference.
  - TRACK: s_an illegal -> IDLE. (idx, s_seg) differs from reference -> stay TRACK, counter=1, reload reference. Match -> counter+1; when counter reaches STABLE_CYCLES -> commit, go LOCKED.
  - LOCKED: match -> stay, no further commits. s_an illegal -> IDLE. Mismatch -> TRACK, counter=1, reload reference.
- Latency: inputs constant from before edge 1 -> s_* captured at edge 1 -> commit registered at edge STABLE_CYCLES+1; upd high in the following cycle only.
- Commit (registered outputs, one cycle):
  - Legal glyph: digits[idx]=decoded nibble, dig_valid[idx]=1, upd=1, upd_idx=idx, dig_err=0.
  - Blank pattern 7'h7F: dig_valid[idx]=0, digits[idx] unchanged, upd=1, dig_err=0.
  - Any other pattern: dig_valid[idx]=0, digits[idx] unchanged, upd=1, dig_err=1.
  - Other digits are never modified by a commit.
- Decode table (seg_n hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 27->C, 21->D, 04->E, 0E->F.
- Counter saturates at STABLE_CYCLES; no wrap.
- Reset mid-TRACK: the pending commit is discarded and all stored digits are cleared.
- Anode index above NUM_DIG-1 is impossible by width; upd_idx bits above log2(NUM_DIG) read 0.

Optional Feature:
SSEG_DP_EN: when defined, add input dp_n (1 bit, active low) and output dp (NUM_DIG bits). dp_n is registered with seg_n, is included in the reference match, and dp[idx]=~dp_n is written on every commit, including blank and illegal commits. When undefined, there are no dp ports, and decoding uses seg_n only.

Test Plan:
- Reset then idle (an_n all ones for 50 cycles) -> upd never asserts, digits=0, dig_valid=0.
- an_n=4'b1110, seg_n=7'h30 held, STABLE_CYCLES=4 -> upd high in the cycle after edge 5 only, upd_idx=0, digits[3:0]=3, dig_valid=4'b0001.
- Scan 4 digits, 6 cycles each, patterns 12/40/0E/79 -> digits=16'h1F05, dig_valid=4'hF, exactly 4 upd pulses per scan round.
- an_n=4'b1101 for 3 cycles, then 4'b1110, both with seg_n=7'h24 -> the first slot does not commit; the second commits idx 0 value 2.
- seg_n=7'h7F on digit 2, then seg_n=7'h55 on digit 2 -> both commits give upd=1 and dig_valid[2]=0; dig_err=0 for the blank, dig_err=1 for 0x55; digits[11:8] unchanged.
- an_n=4'b1100 (two low) for 10 cycles -> no commit; rst asserted at cycle 3 of TRACK -> no upd, all outputs zero.
